// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared definitions for the nibble-serial ALU: op codes, FSM encodings, default sizes
// and the signed-overflow helper used when ALU_OVERFLOW_EN is defined.
package nibble_serial_alu_ctrl_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SLICE = 4;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_NOT = 3'b011;
    localparam logic [2:0] ALU_OP_ADD = 3'b100;
    localparam logic [2:0] ALU_OP_SUB = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Two's-complement overflow from operand signs and the result sign bit.
    function automatic logic ovf_flag(input logic [2:0] op, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
        logic flag_s;
        case (op)
            ALU_OP_ADD: flag_s = (sign_a == sign_b) && (sign_r != sign_a);
            ALU_OP_SUB: flag_s = (sign_a != sign_b) && (sign_r != sign_a);
            default:    flag_s = 1'b0;
        endcase
        return flag_s;
    endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl_slice.sv
// Combinational SLICE-wide ALU slice (AND/OR/XOR/NOT/ADD/SUB), reusable by serial or
// parallel ALUs. SUB is a + ~b + cin; the caller seeds cin=1 on the first slice.
module four_bit_alu_slice
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int SLICE = ALU_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y,
    output logic             cout
);

    logic [SLICE:0] sum_s;
    logic [SLICE-1:0] b_eff_s;

    // Slice datapath; logic and reserved ops never produce a carry.
    always_comb begin
        b_eff_s = (op == ALU_OP_SUB) ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{SLICE{1'b0}}, cin};
        y       = {SLICE{1'b0}};
        cout    = 1'b0;
        case (op)
            ALU_OP_AND: y = a & b;
            ALU_OP_OR:  y = a | b;
            ALU_OP_XOR: y = a ^ b;
            ALU_OP_NOT: y = ~a;
            ALU_OP_ADD,
            ALU_OP_SUB: begin
                y    = sum_s[SLICE-1:0];
                cout = sum_s[SLICE];
            end
            default: begin
                y    = {SLICE{1'b0}};
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-cycle WIDTH-bit ALU sequencing one shared SLICE-wide slice, LSB nibble first,
// with a start/busy/done handshake. Define ALU_OVERFLOW_EN to add the overflow output.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = ALU_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             carry_r;
    logic [WIDTH-1:0] result_sr_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_out_r;
    logic             zero_r;

    logic [SLICE-1:0] slice_y_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] final_result_s;
    logic             accept_s;
    logic             last_s;

    four_bit_alu_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_r[SLICE-1:0]),
        .b    (b_r[SLICE-1:0]),
        .cin  (carry_r),
        .op   (op_r),
        .y    (slice_y_s),
        .cout (slice_cout_s)
    );

    assign accept_s       = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s         = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    assign final_result_s = {slice_y_s, result_sr_r[WIDTH-1:SLICE]};

    // Sequencer, operand/result shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= 3'b000;
            carry_r     <= 1'b0;
            result_sr_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE,
                ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r     <= ST_RUN;
                        busy_r      <= 1'b1;
                        a_r         <= a;
                        b_r         <= b;
                        op_r        <= op;
                        cnt_r       <= '0;
                        carry_r     <= (op == ALU_OP_SUB);
                        result_sr_r <= '0;
                        result_r    <= '0;
                        carry_out_r <= 1'b0;
                        zero_r      <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r         <= a_r >> SLICE;
                    b_r         <= b_r >> SLICE;
                    result_sr_r <= final_result_s;
                    carry_r     <= slice_cout_s;
                    cnt_r       <= cnt_r + 1'b1;
                    // Outputs are loaded on the last slice so they are valid in DONE.
                    if (last_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        result_r    <= final_result_s;
                        carry_out_r <= slice_cout_s;
                        zero_r      <= (final_result_s == '0);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign zero      = zero_r;

`ifdef ALU_OVERFLOW_EN
    logic sign_a_r;
    logic sign_b_r;
    logic overflow_r;

    // Operand sign bits are captured separately since a_r/b_r are shifted away.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            sign_a_r   <= a[WIDTH-1];
            sign_b_r   <= b[WIDTH-1];
            overflow_r <= 1'b0;
        end else if (last_s) begin
            overflow_r <= ovf_flag(op_r, sign_a_r, sign_b_r, slice_y_s[SLICE-1]);
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Randomized and directed bench for nibble_serial_alu_ctrl against a word-level
// arithmetic reference model.
module tb_nibble_serial_alu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int tests_run;
    int tests_failed;

    nibble_serial_alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns {carry, result}.
    function automatic logic [32:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        case (mop)
            3'd0: return {1'b0, ma & mb};
            3'd1: return {1'b0, ma | mb};
            3'd2: return {1'b0, ma ^ mb};
            3'd3: return {1'b0, ~ma};
            3'd4: return {1'b0, ma} + {1'b0, mb};
            3'd5: return {(ma >= mb), ma - mb};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [2:0] mop, input logic [31:0] ma,
                                       input logic [31:0] mb);
        longint sa, sb, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            3'd4: r = sa + sb;
            3'd5: r = sa - sb;
            default: r = 0;
        endcase
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Present an operation at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] iop,
                                 input logic [31:0] ia, input logic [31:0] ib);
        logic [32:0] exp;
        exp = model(iop, ia, ib);
        check_val({tag, "_result"}, result, exp[31:0]);
        check_val({tag, "_carry"}, 32'(carry_out), 32'(exp[32]));
        check_val({tag, "_zero"}, 32'(zero), 32'(exp[31:0] == 32'd0));
`ifdef ALU_OVERFLOW_EN
        check_val({tag, "_ovf"}, 32'(overflow), 32'(model_ovf(iop, ia, ib)));
`endif
    endtask

    task automatic run_op(input string tag, input logic [2:0] iop,
                          input logic [31:0] ia, input logic [31:0] ib);
        int n;
        issue(iop, ia, ib);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check_val({tag, "_latency"}, 32'(n), 32'd8);
        check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_outputs(tag, iop, ia, ib);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_outputs({tag, "_hold"}, iop, ia, ib);
    endtask

    initial begin
        int n;
        int pulses;
        int first_at;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_carry", 32'(carry_out), 32'd0);
        check_val("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_wrap", 3'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("sub_neg", 3'd5, 32'd5, 32'd7);
        run_op("sub_ovf", 3'd5, 32'h8000_0000, 32'h0000_0001);
        run_op("not", 3'd3, 32'h0F0F_0F0F, 32'h1234_5678);
        run_op("xor_self", 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("rsvd", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("add_ovf", 3'd4, 32'h7FFF_FFFF, 32'h0000_0001);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            run_op("rand", 3'($urandom_range(0, 7)), ra, rb);
        end

        // start re-asserted during RUN must be ignored.
        issue(3'd4, 32'h1111_1111, 32'h2222_2222);
        pulses   = 0;
        first_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i;
                    check_val("ign_result", result, 32'h3333_3333);
                end
            end
            start = (i >= 1 && i <= 4);
            a     = $urandom;
            b     = $urandom;
        end
        start = 1'b0;
        check_val("ign_pulses", 32'(pulses), 32'd1);
        check_val("ign_latency", 32'(first_at), 32'd8);

        // Synchronous reset mid-operation aborts without a done pulse.
        issue(3'd4, 32'hAAAA_0000, 32'h0000_5555);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_result", result, 32'd0);
        check_val("abort_carry", 32'(carry_out), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("abort_no_done", 32'(pulses), 32'd0);
        run_op("add_after_rst", 3'd4, 32'd3, 32'd4);

        // start held high: operand changes in RUN ignored, back-to-back accept in DONE.
        start = 1'b1;
        op    = 3'd4;
        a     = 32'd1;
        b     = 32'd2;
        @(posedge clk);
        @(negedge clk);
        op = 3'd0;
        a  = 32'hFF00_FF00;
        b  = 32'h0FF0_0FF0;
        wait_done(n);
        check_val("b2b_first_latency", 32'(n), 32'd8);
        check_val("b2b_first_result", result, 32'd3);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("b2b_accept_busy", 32'(busy), 32'd1);
        check_val("b2b_accept_clear", result, 32'd0);
        wait_done(n);
        check_val("b2b_spacing", 32'(n + 1), 32'd9);
        check_outputs("b2b_second", 3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
